uart_tx_fifo: RTL

//  Parametrised UART transmitter with a sync FIFO and in-block baud divider; runs on the system clock (no derived clocks).

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_tx_fifo_if.sv | 10 +
 rtl/uart_tx_fifo_sync_fifo.sv | 44 ++++
 rtl/uart_tx_fifo.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and elaboration helpers for the UART transmitter.
// FSM encodings gain a PARITY state only when UART_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
`ifdef UART_PARITY_EN
    , ST_PARITY
`endif
  } state_e;

  // Ceiling log2 used for register widths; never returns less than 1.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic bit params_legal(input int clk_div, input int data_bits,
                                      input int stop_bits, input int fifo_depth,
                                      input int parity_odd);
    return (clk_div >= 2) && (data_bits >= 5) && (data_bits <= 9) &&
           (stop_bits >= 1) && (stop_bits <= 4) && (fifo_depth >= 2) &&
           ((fifo_depth & (fifo_depth - 1)) == 0) &&
           ((parity_odd == 0) || (parity_odd == 1));
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer-side word handshake into the UART transmitter.
interface uart_tx_fifo_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] s_data;
  logic                 s_valid;
  logic                 s_ready;
  logic                 overrun;

  modport master (output s_data, s_valid, input s_ready, overrun);
  modport slave  (input s_data, s_valid, output s_ready, overrun);
endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; registered-pointer flags, no fall-through.
module sync_fifo import uart_pkg::*; #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter, LSB first, baud divider on the system clock.
// Optional parity bit after the data bits when UART_PARITY_EN is defined.
module uart_tx_fifo import uart_pkg::*; #(
  parameter  int CLK_DIV    = 4,
  parameter  int DATA_BITS  = 8,
  parameter  int STOP_BITS  = 1,
  parameter  int FIFO_DEPTH = 4,
  parameter  int PARITY_ODD = 0,
  localparam int LVL_W      = clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_fifo_if.slave    s,
  output logic             tx,
  output logic             busy,
  output logic [LVL_W-1:0] fifo_level
);

  if (!params_legal(CLK_DIV, DATA_BITS, STOP_BITS, FIFO_DEPTH, PARITY_ODD)) begin : g_bad_params
    $error("uart_tx_fifo: illegal parameter combination");
  end

  localparam int CNT_W = clog2(CLK_DIV);
  localparam int IDX_W = clog2(DATA_BITS);
  localparam int STP_W = clog2(STOP_BITS);

  state_e               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [IDX_W-1:0]     bit_idx, bit_idx_n;
  logic [STP_W-1:0]     stop_idx, stop_idx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [DATA_BITS-1:0] rd_data;
  logic                 tx_n, pop, load, full, empty, pending, bit_end;
`ifdef UART_PARITY_EN
  logic                 par, par_n;
`endif

  sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (s.s_valid),
    .pop     (pop),
    .wr_data (s.s_data),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  assign s.s_ready = !full;
  assign s.overrun = s.s_valid && full;
  assign busy      = (state != ST_IDLE) || (fifo_level != '0);
  assign bit_end   = (cnt == CNT_W'(CLK_DIV - 1));

  always_comb begin
    state_n    = state;
    cnt_n      = '0;
    bit_idx_n  = bit_idx;
    stop_idx_n = stop_idx;
    shift_n    = shift;
    tx_n       = tx;
    load       = 1'b0;
    pop        = 1'b0;
`ifdef UART_PARITY_EN
    par_n      = par;
`endif
    if (state != ST_IDLE && !bit_end) cnt_n = cnt + 1'b1;
    case (state)
      ST_IDLE:  load = pending;
      ST_START: if (bit_end) begin
        tx_n      = shift[0];
        shift_n   = shift >> 1;
        bit_idx_n = '0;
        state_n   = ST_DATA;
      end
      ST_DATA: if (bit_end) begin
        if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
          tx_n       = par;
          state_n    = ST_PARITY;
`else
          tx_n       = 1'b1;
          stop_idx_n = '0;
          state_n    = ST_STOP;
`endif
        end else begin
          tx_n      = shift[0];
          shift_n   = shift >> 1;
          bit_idx_n = bit_idx + 1'b1;
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: if (bit_end) begin
        tx_n       = 1'b1;
        stop_idx_n = '0;
        state_n    = ST_STOP;
      end
`endif
      ST_STOP: if (bit_end) begin
        if (stop_idx == STP_W'(STOP_BITS - 1)) begin
          // Back-to-back frames: next start bit follows the stop bit directly.
          load = pending;
          if (!pending) state_n = ST_IDLE;
        end else begin
          stop_idx_n = stop_idx + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (load) begin
      pop     = 1'b1;
      shift_n = rd_data;
      tx_n    = 1'b0;
      state_n = ST_START;
`ifdef UART_PARITY_EN
      par_n   = (^rd_data) ^ 1'(PARITY_ODD);
`endif
    end
  end

  // pending is the registered non-empty flag the FSM acts on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      pending  <= 1'b0;
`ifdef UART_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_idx_n;
      stop_idx <= stop_idx_n;
      shift    <= shift_n;
      tx       <= tx_n;
      pending  <= !empty;
`ifdef UART_PARITY_EN
      par      <= par_n;
`endif
    end
  end

endmodule
